// File: rtl/bus_arbiter_if.sv
// Bus-side signals of the central arbiter. The master modport is the arbiter's view;
// the slave modport is the view of the requesting masters and the split-capable slave.
interface bus_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int MSEL_W      = 1
);
   logic [NUM_MASTERS-1:0] mreq;
   logic [NUM_MASTERS-1:0] mgrant;
   logic [NUM_MASTERS-1:0] msplit;
   logic [MSEL_W-1:0]      msel;
   logic                   bus_busy;
   logic                   ssplit;
   logic                   split_grant;

   modport master (
      input  mreq,
      input  ssplit,
      output mgrant,
      output msplit,
      output msel,
      output bus_busy,
      output split_grant
   );

   modport slave (
      output mreq,
      output ssplit,
      input  mgrant,
      input  msplit,
      input  msel,
      input  bus_busy,
      input  split_grant
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a single outstanding split transaction: the split
// master is parked, the bus is freed, and the owner is later re-granted with split_grant.
module bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int MSEL_W      = 1
) (
   input  logic            clk,
   input  logic            rstn,
   bus_arbiter_if.master   bus
);

   typedef enum logic [1:0] {IDLE, RESUME, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] mgrant_q, mgrant_d;
   logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
   logic [MSEL_W-1:0]      owner_q, owner_d;
   logic [MSEL_W-1:0]      split_owner_q, split_owner_d;
   logic [MSEL_W-1:0]      rr_last_q, rr_last_d;
   logic                   split_pending_q, split_pending_d;
   logic                   split_grant_q, split_grant_d;

   logic [NUM_MASTERS-1:0] eligible;
   logic                   found;
   logic [MSEL_W-1:0]      winner;
   logic                   found_hi;
   logic [MSEL_W-1:0]      winner_hi;
   logic [MSEL_W-1:0]      winner_lo;

   assign eligible = bus.mreq & ~msplit_q;

   // Lowest eligible index above rr_last wins; otherwise wrap to the lowest eligible overall.
   always_comb begin
      found     = 1'b0;
      found_hi  = 1'b0;
      winner_hi = '0;
      winner_lo = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            found     = 1'b1;
            winner_lo = MSEL_W'(i);
            if (i > int'(rr_last_q)) begin
               found_hi  = 1'b1;
               winner_hi = MSEL_W'(i);
            end
         end
      end
      winner = found_hi ? winner_hi : winner_lo;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= IDLE;
         mgrant_q        <= '0;
         msplit_q        <= '0;
         owner_q         <= '0;
         split_owner_q   <= '0;
         rr_last_q       <= MSEL_W'(NUM_MASTERS - 1);
         split_pending_q <= 1'b0;
         split_grant_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         mgrant_q        <= mgrant_d;
         msplit_q        <= msplit_d;
         owner_q         <= owner_d;
         split_owner_q   <= split_owner_d;
         rr_last_q       <= rr_last_d;
         split_pending_q <= split_pending_d;
         split_grant_q   <= split_grant_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      mgrant_d        = mgrant_q;
      msplit_d        = msplit_q;
      owner_d         = owner_q;
      split_owner_d   = split_owner_q;
      rr_last_d       = rr_last_q;
      split_pending_d = split_pending_q;
      split_grant_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            mgrant_d = '0;
            if (split_pending_q && !bus.ssplit) begin
               state_d       = RESUME;
               owner_d       = split_owner_q;
               mgrant_d      = NUM_MASTERS'(1) << split_owner_q;
               split_grant_d = 1'b1;
            end else if (found) begin
               state_d  = BUSY;
               owner_d  = winner;
               mgrant_d = NUM_MASTERS'(1) << winner;
            end
         end
         RESUME: begin
            state_d         = BUSY;
            msplit_d        = '0;
            split_pending_d = 1'b0;
         end
         BUSY: begin
            // A split takes precedence over a simultaneous release by the owner.
            if (bus.ssplit && !split_pending_q) begin
               state_d         = IDLE;
               split_owner_d   = owner_q;
               split_pending_d = 1'b1;
               msplit_d        = NUM_MASTERS'(1) << owner_q;
               mgrant_d        = '0;
               rr_last_d       = owner_q;
            end else if (!bus.mreq[owner_q]) begin
               state_d   = IDLE;
               mgrant_d  = '0;
               rr_last_d = owner_q;
            end
         end
         default: begin
            state_d  = IDLE;
            mgrant_d = '0;
         end
      endcase
   end

   assign bus.mgrant      = mgrant_q;
   assign bus.msplit      = msplit_q;
   assign bus.msel        = owner_q;
   assign bus.bus_busy    = |mgrant_q;
   assign bus.split_grant = split_grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single/alternating grants, split and resume.
module tb_bus_arbiter;

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_errors;

   bus_arbiter_if #(.NUM_MASTERS(2), .MSEL_W(1)) bus_if ();

   bus_arbiter #(.NUM_MASTERS(2), .MSEL_W(1)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", tag, got, $time);
      end
   endtask

   // Advance one rising edge and settle before sampling/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_bus(input string tag, input logic [1:0] grant, input logic [1:0] split,
                             input logic sg, input logic sel);
      check({tag, ".mgrant"}, 32'(bus_if.mgrant), 32'(grant));
      check({tag, ".msplit"}, 32'(bus_if.msplit), 32'(split));
      check({tag, ".split_grant"}, 32'(bus_if.split_grant), 32'(sg));
      check({tag, ".bus_busy"}, 32'(bus_if.bus_busy), 32'(|grant));
      check({tag, ".msel"}, 32'(bus_if.msel), 32'(sel));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rstn = 1'b0;
      bus_if.mreq   = 2'b00;
      bus_if.ssplit = 1'b0;
      step();
      step();
      expect_bus("reset", 2'b00, 2'b00, 1'b0, 1'b0);
      rstn = 1'b1;
      step();
      expect_bus("idle", 2'b00, 2'b00, 1'b0, 1'b0);

      // Single master: 1-cycle grant latency, release one cycle after mreq falls.
      bus_if.mreq = 2'b01;
      step();
      expect_bus("m0_grant", 2'b01, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("m0_hold", 32'(bus_if.mgrant), 32'h1);
      end
      bus_if.mreq = 2'b00;
      step();
      expect_bus("m0_release", 2'b00, 2'b00, 1'b0, 1'b0);

      // Async reset while M1 owns the bus clears everything without a clock edge.
      bus_if.mreq = 2'b10;
      step();
      expect_bus("m1_grant", 2'b10, 2'b00, 1'b0, 1'b1);
      bus_if.mreq = 2'b00;
      rstn = 1'b0;
      #1;
      expect_bus("async_reset", 2'b00, 2'b00, 1'b0, 1'b0);
      step();
      rstn = 1'b1;
      step();

      // Both requesting: alternate 01,10,01 with one IDLE cycle between owners.
      bus_if.mreq = 2'b11;
      step();
      expect_bus("rr_first", 2'b01, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      check("rr_first_hold", 32'(bus_if.mgrant), 32'h1);
      bus_if.mreq = 2'b10;
      step();
      expect_bus("rr_gap1", 2'b00, 2'b00, 1'b0, 1'b0);
      bus_if.mreq = 2'b11;
      step();
      expect_bus("rr_second", 2'b10, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step();
      check("rr_second_hold", 32'(bus_if.mgrant), 32'h2);
      bus_if.mreq = 2'b01;
      step();
      expect_bus("rr_gap2", 2'b00, 2'b00, 1'b0, 1'b1);
      bus_if.mreq = 2'b11;
      step();
      expect_bus("rr_third", 2'b01, 2'b00, 1'b0, 1'b0);
      bus_if.mreq = 2'b00;
      step();
      check("rr_done", 32'(bus_if.mgrant), 32'h0);

      // Split of M0 while M1 waits; M1 served, then M0 resumed with split_grant.
      bus_if.mreq = 2'b01;
      step();
      expect_bus("sp_m0", 2'b01, 2'b00, 1'b0, 1'b0);
      bus_if.mreq   = 2'b11;
      bus_if.ssplit = 1'b1;
      step();
      expect_bus("sp_parked", 2'b00, 2'b01, 1'b0, 1'b0);
      step();
      expect_bus("sp_m1", 2'b10, 2'b01, 1'b0, 1'b1);
      step();
      expect_bus("sp_ssplit_ignored", 2'b10, 2'b01, 1'b0, 1'b1);
      bus_if.ssplit = 1'b0;
      step();
      expect_bus("sp_wait_owner", 2'b10, 2'b01, 1'b0, 1'b1);
      bus_if.mreq = 2'b01;
      step();
      expect_bus("sp_m1_release", 2'b00, 2'b01, 1'b0, 1'b1);
      step();
      check("sp_resume.mgrant", 32'(bus_if.mgrant), 32'h1);
      check("sp_resume.split_grant", 32'(bus_if.split_grant), 32'h1);
      check("sp_resume.msel", 32'(bus_if.msel), 32'h0);
      step();
      expect_bus("sp_after_resume", 2'b01, 2'b00, 1'b0, 1'b0);
      bus_if.mreq = 2'b00;
      step();
      expect_bus("sp_done", 2'b00, 2'b00, 1'b0, 1'b0);

      // Split and owner release on the same edge: split wins; lone master resumes.
      bus_if.mreq = 2'b01;
      step();
      expect_bus("lone_grant", 2'b01, 2'b00, 1'b0, 1'b0);
      bus_if.mreq   = 2'b00;
      bus_if.ssplit = 1'b1;
      step();
      expect_bus("lone_split_wins", 2'b00, 2'b01, 1'b0, 1'b0);
      bus_if.mreq = 2'b01;
      step();
      expect_bus("lone_masked", 2'b00, 2'b01, 1'b0, 1'b0);
      bus_if.ssplit = 1'b0;
      step();
      check("lone_resume.mgrant", 32'(bus_if.mgrant), 32'h1);
      check("lone_resume.split_grant", 32'(bus_if.split_grant), 32'h1);
      step();
      expect_bus("lone_busy1", 2'b01, 2'b00, 1'b0, 1'b0);
      step();
      expect_bus("lone_busy2", 2'b01, 2'b00, 1'b0, 1'b0);
      bus_if.mreq = 2'b00;
      step();
      expect_bus("lone_release", 2'b00, 2'b00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
